// File: rtl/reg_write_scheduler.sv
`default_nettype none
// ============================================================================
// reg_write_scheduler: merges load and ALU results onto one register-file write port
// Revision: 1.0
// ============================================================================
module reg_write_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_address,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_address,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  output logic        write_enable,
  output logic [4:0]  address,
  output logic [31:0] data,
  input  logic [4:0]  src1_address,
  input  logic [4:0]  src2_address,
  output logic        src1_pending,
  output logic        src2_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;

  logic          acc_mem, acc_alu, acc_nz;
  logic          fifo_empty, push, pop;
  logic [4:0]    acc_addr;
  logic [31:0]   acc_data;
  logic [PW-1:0] off;

  assign mem_ready  = !rst && (count_q < FULL);
  assign alu_ready  = mem_ready && !mem_valid;
  assign acc_mem    = mem_valid && mem_ready;
  assign acc_alu    = alu_valid && alu_ready;
  assign acc_addr   = acc_mem ? mem_address : alu_address;
  assign acc_data   = acc_mem ? mem_data : alu_data;
  // Writes to x0 finish the handshake but never reach the queue or the port.
  assign acc_nz     = (acc_mem || acc_alu) && (acc_addr != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty;
  assign push       = acc_nz && !fifo_empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (pop) begin
      we_d     = 1'b1;
      addr_d   = fifo_addr_q[rd_ptr_q];
      data_d   = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (acc_nz) begin
      we_d   = 1'b1;
      addr_d = acc_addr;
      data_d = acc_data;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: entries outside [rd_ptr, rd_ptr+count) are ignored.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= acc_addr;
      fifo_data_q[wr_ptr_q] <= acc_data;
    end
  end

  always_comb begin
    off          = '0;
    src1_pending = we_q && (addr_q == src1_address);
    src2_pending = we_q && (addr_q == src2_address);
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (fifo_addr_q[i] == src1_address) src1_pending = 1'b1;
        if (fifo_addr_q[i] == src2_address) src2_pending = 1'b1;
      end
    end
    src1_pending = src1_pending && (src1_address != 5'd0);
    src2_pending = src2_pending && (src2_address != 5'd0);
  end

  assign write_enable = we_q;
  assign address      = addr_q;
  assign data         = data_q;

endmodule
`default_nettype wire
